// File: rtl/ime_pkg.sv
// Shared defaults, types and helpers for the IME KL frame accumulator.
package ime_pkg;

   localparam int IME_W_P   = 16;
   localparam int IME_W_LOG = 16;
   localparam int IME_W_ACC = 32;
   localparam int IME_K_MAX = 4096;
   localparam int IME_W_CNT = $clog2(IME_K_MAX + 1);

   typedef logic signed [IME_W_LOG+1:0] kl_term_t;
   typedef logic signed [IME_W_ACC-1:0] kl_acc_t;

   typedef struct packed {
      logic poison;
      logic trunc;
      logic sat;
   } ime_kl_status_t;

   // Signed add clamped to a w-bit two's complement range (w <= 62).
   function automatic logic signed [63:0] sat_add(
      input  logic signed [63:0] a,
      input  logic signed [63:0] b,
      input  int                 w,
      output logic               sat
   );
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo  = -hi - 64'sd1;
      s   = a + b;
      sat = 1'b0;
      if (s > hi) begin
         s   = hi;
         sat = 1'b1;
      end else if (s < lo) begin
         s   = lo;
         sat = 1'b1;
      end
      return s;
   endfunction

endpackage

// File: rtl/ime_kl_term_mul.sv
// Per-beat KL term: prob_p * (log_p - log_q), arithmetic shift by W_P.
module ime_kl_term_mul #(
   parameter int W_P   = 16,
   parameter int W_LOG = 16
) (
   input  logic [W_LOG-1:0]        log_p,
   input  logic [W_LOG-1:0]        log_q,
   input  logic [W_P-1:0]          prob_p,
   output logic signed [W_LOG+1:0] term
);

   localparam int W_PROD = W_P + W_LOG + 2;

   logic signed [W_LOG:0]     diff;
   logic signed [W_P:0]       prob_s;
   logic signed [W_PROD-1:0]  prod;

   assign diff   = $signed({1'b0, log_p}) - $signed({1'b0, log_q});
   assign prob_s = $signed({1'b0, prob_p});
   assign prod   = W_PROD'(prob_s) * W_PROD'(diff);

   // Dropping the low W_P bits of a two's complement value floors it.
   assign term   = prod[W_PROD-1:W_P];

endmodule

// File: rtl/ime_kl_accum.sv
// Frame accumulator for KL terms, score sum and beat counts.
// Define IME_KL_ACC_SAT_EN for a clamping KL accumulator.
module ime_kl_accum
   import ime_pkg::*;
#(
   parameter  int W_P   = IME_W_P,
   parameter  int W_LOG = IME_W_LOG,
   parameter  int W_ACC = IME_W_ACC,
   parameter  int K_MAX = IME_K_MAX,
   localparam int W_CNT = $clog2(K_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_LOG-1:0] in_log_p,
   input  logic [W_LOG-1:0] in_log_q,
   input  logic [W_LOG-1:0] in_log_score,
   input  logic [W_P-1:0]   in_prob_p,
   input  logic [7:0]       in_tuser,
   input  logic             in_last,
   input  logic             in_use_pwl,
   input  logic             in_poison,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_ACC-1:0] out_kl,
   output logic [W_ACC-1:0] out_score_sum,
   output logic [W_CNT-1:0] out_count,
   output logic [W_CNT-1:0] out_pwl_count,
   output logic [7:0]       out_tuser,
   output logic             out_poison,
   output logic             out_trunc,
   output logic             out_sat
);

   localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(K_MAX);

   logic signed [W_LOG+1:0] term;
   logic signed [W_ACC-1:0] term_ext;
   logic signed [W_ACC-1:0] acc;
   logic signed [W_ACC-1:0] acc_nx;
   logic [W_ACC-1:0]        score;
   logic [W_ACC-1:0]        score_nx;
   logic [W_ACC:0]          score_sum;
   logic [W_CNT-1:0]        cnt;
   logic [W_CNT-1:0]        cnt_nx;
   logic [W_CNT-1:0]        pwl;
   logic [W_CNT-1:0]        pwl_nx;
   logic [7:0]              tuser;
   logic [7:0]              tuser_nx;
   logic                    first_beat;
   logic                    poison_r;
   logic                    sat_r;
   logic                    clamp;
   logic                    accept;
   logic                    close;
   ime_kl_status_t          status_nx;
   ime_kl_status_t          out_status;

   ime_kl_term_mul #(
      .W_P   (W_P),
      .W_LOG (W_LOG)
   ) u_mul (
      .log_p  (in_log_p),
      .log_q  (in_log_q),
      .prob_p (in_prob_p),
      .term   (term)
   );

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign term_ext = W_ACC'(term);

   always_comb begin
      clamp  = 1'b0;
`ifdef IME_KL_ACC_SAT_EN
      acc_nx = W_ACC'(sat_add(64'(acc), 64'(term_ext), W_ACC, clamp));
`else
      acc_nx = acc + term_ext;
`endif
      score_sum = (W_ACC+1)'(score) + (W_ACC+1)'(in_log_score);
      score_nx  = score_sum[W_ACC] ? '1 : score_sum[W_ACC-1:0];
      cnt_nx    = cnt + 1'b1;
      pwl_nx    = pwl + W_CNT'(in_use_pwl);
      tuser_nx  = first_beat ? in_tuser : tuser;
      status_nx.poison = poison_r | in_poison;
      status_nx.sat    = sat_r | clamp;
      // A frame ended by in_last is complete even on its K_MAX-th beat.
      status_nx.trunc  = (cnt_nx == CNT_MAX) && !in_last;
      close = accept && (in_last || (cnt_nx == CNT_MAX));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc           <= '0;
         score         <= '0;
         cnt           <= '0;
         pwl           <= '0;
         tuser         <= '0;
         poison_r      <= 1'b0;
         sat_r         <= 1'b0;
         first_beat    <= 1'b1;
         out_valid     <= 1'b0;
         out_kl        <= '0;
         out_score_sum <= '0;
         out_count     <= '0;
         out_pwl_count <= '0;
         out_tuser     <= '0;
         out_status    <= '0;
      end else if (close) begin
         out_valid     <= 1'b1;
         out_kl        <= status_nx.poison ? '0 : acc_nx;
         out_score_sum <= score_nx;
         out_count     <= cnt_nx;
         out_pwl_count <= pwl_nx;
         out_tuser     <= tuser_nx;
         out_status    <= status_nx;
         acc           <= '0;
         score         <= '0;
         cnt           <= '0;
         pwl           <= '0;
         tuser         <= '0;
         poison_r      <= 1'b0;
         sat_r         <= 1'b0;
         first_beat    <= 1'b1;
      end else begin
         if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            acc        <= acc_nx;
            score      <= score_nx;
            cnt        <= cnt_nx;
            pwl        <= pwl_nx;
            tuser      <= tuser_nx;
            poison_r   <= status_nx.poison;
            sat_r      <= status_nx.sat;
            first_beat <= 1'b0;
         end
      end
   end

   assign out_poison = out_status.poison;
   assign out_trunc  = out_status.trunc;
   assign out_sat    = out_status.sat;

endmodule

// File: tb/tb_ime_kl_accum.sv
// Self-checking bench for ime_kl_accum: default, K_MAX=4 and W_ACC=18 builds.
module tb_ime_kl_accum;

`ifdef IME_KL_ACC_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [15:0] p;
      logic [15:0] lp;
      logic [15:0] lq;
      logic [15:0] sc;
      logic [7:0]  tu;
      logic        last;
      logic        pwl;
      logic        pz;
   } beat_t;

   typedef struct {
      longint     kl;
      longint     score;
      int         count;
      int         pwl;
      logic [7:0] tu;
      logic       pz;
      logic       tr;
      logic       st;
   } rec_t;

   typedef struct {
      logic [15:0] p;
      logic [15:0] lp;
      logic [15:0] lq;
      logic [15:0] sc;
      logic [7:0]  tu;
      logic        pwl;
      logic        pz;
      longint      kl;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] in_log_p = '0;
   logic [15:0] in_log_q = '0;
   logic [15:0] in_log_score = '0;
   logic [15:0] in_prob_p = '0;
   logic [7:0]  in_tuser = '0;
   logic        in_last = 1'b0;
   logic        in_use_pwl = 1'b0;
   logic        in_poison = 1'b0;
   logic [2:0]  sel = 3'b001;

   logic        o0_ready, o0_valid, o0_pz, o0_tr, o0_st;
   logic [31:0] o0_kl, o0_score;
   logic [12:0] o0_count, o0_pwl;
   logic [7:0]  o0_tu;
   logic        o1_ready, o1_valid, o1_pz, o1_tr, o1_st;
   logic [31:0] o1_kl, o1_score;
   logic [2:0]  o1_count, o1_pwl;
   logic [7:0]  o1_tu;
   logic        o2_ready, o2_valid, o2_pz, o2_tr, o2_st;
   logic [17:0] o2_kl, o2_score;
   logic [12:0] o2_count, o2_pwl;
   logic [7:0]  o2_tu;

   ime_kl_accum u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid & sel[0]), .in_ready(o0_ready),
      .in_log_p(in_log_p), .in_log_q(in_log_q),
      .in_log_score(in_log_score), .in_prob_p(in_prob_p),
      .in_tuser(in_tuser), .in_last(in_last),
      .in_use_pwl(in_use_pwl), .in_poison(in_poison),
      .out_valid(o0_valid), .out_ready(out_ready),
      .out_kl(o0_kl), .out_score_sum(o0_score),
      .out_count(o0_count), .out_pwl_count(o0_pwl),
      .out_tuser(o0_tu), .out_poison(o0_pz),
      .out_trunc(o0_tr), .out_sat(o0_st)
   );

   ime_kl_accum #(.K_MAX(4)) u_k4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid & sel[1]), .in_ready(o1_ready),
      .in_log_p(in_log_p), .in_log_q(in_log_q),
      .in_log_score(in_log_score), .in_prob_p(in_prob_p),
      .in_tuser(in_tuser), .in_last(in_last),
      .in_use_pwl(in_use_pwl), .in_poison(in_poison),
      .out_valid(o1_valid), .out_ready(out_ready),
      .out_kl(o1_kl), .out_score_sum(o1_score),
      .out_count(o1_count), .out_pwl_count(o1_pwl),
      .out_tuser(o1_tu), .out_poison(o1_pz),
      .out_trunc(o1_tr), .out_sat(o1_st)
   );

   ime_kl_accum #(.W_ACC(18)) u_a18 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid & sel[2]), .in_ready(o2_ready),
      .in_log_p(in_log_p), .in_log_q(in_log_q),
      .in_log_score(in_log_score), .in_prob_p(in_prob_p),
      .in_tuser(in_tuser), .in_last(in_last),
      .in_use_pwl(in_use_pwl), .in_poison(in_poison),
      .out_valid(o2_valid), .out_ready(out_ready),
      .out_kl(o2_kl), .out_score_sum(o2_score),
      .out_count(o2_count), .out_pwl_count(o2_pwl),
      .out_tuser(o2_tu), .out_poison(o2_pz),
      .out_trunc(o2_tr), .out_sat(o2_st)
   );

   function automatic rec_t mk(
      input longint kl, input longint sc, input int cnt,
      input int pw, input logic [7:0] tu,
      input logic pz, input logic tr, input logic st
   );
      rec_t r;
      r.kl = kl; r.score = sc; r.count = cnt; r.pwl = pw;
      r.tu = tu; r.pz = pz; r.tr = tr; r.st = st;
      return r;
   endfunction

   logic m_valid, m_in_ready;
   rec_t m;
   always_comb begin
      if (sel[1]) begin
         m_valid = o1_valid; m_in_ready = o1_ready;
         m = mk($signed(o1_kl), o1_score, o1_count, o1_pwl,
                o1_tu, o1_pz, o1_tr, o1_st);
      end else if (sel[2]) begin
         m_valid = o2_valid; m_in_ready = o2_ready;
         m = mk($signed(o2_kl), o2_score, o2_count, o2_pwl,
                o2_tu, o2_pz, o2_tr, o2_st);
      end else begin
         m_valid = o0_valid; m_in_ready = o0_ready;
         m = mk($signed(o0_kl), o0_score, o0_count, o0_pwl,
                o0_tu, o0_pz, o0_tr, o0_st);
      end
   end

   int checks = 0;
   int failures = 0;
   int bubbles = 0;
   beat_t stim_q[$];
   beat_t beats_q[$];
   rec_t  exp_q[$];
   rec_t  got_q[$];

   task automatic chk(input string name, input longint got,
                      input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic cmp_rec(input string n, input rec_t g, input rec_t e);
      chk({n, " kl"}, g.kl, e.kl);
      chk({n, " score"}, g.score, e.score);
      chk({n, " count"}, g.count, e.count);
      chk({n, " pwl"}, g.pwl, e.pwl);
      chk({n, " tuser"}, g.tu, e.tu);
      chk({n, " poison"}, g.pz, e.pz);
      chk({n, " trunc"}, g.tr, e.tr);
      chk({n, " sat"}, g.st, e.st);
   endtask

   function automatic longint fdiv(input longint n);
      longint q;
      q = n / 65536;
      if (n < 0 && q * 65536 != n) q = q - 1;
      return q;
   endfunction

   function automatic longint wrap(input longint v, input int w);
      longint md;
      md = longint'(1) << w;
      v = v & (md - 1);
      if (v >= (md >> 1)) v = v - md;
      return v;
   endfunction

   // Frame-level reference: plain sums over the beats in stim_q.
   function automatic void model(input int kmax, input int wacc);
      longint kl, sc, hi, lo, umax;
      int n, pw;
      bit pz, st;
      logic [7:0] tu;
      beat_t b;
      rec_t r;
      kl = 0; sc = 0; n = 0; pw = 0; pz = 0; st = 0; tu = 0;
      hi = (longint'(1) << (wacc - 1)) - 1;
      lo = -hi - 1;
      umax = (longint'(1) << wacc) - 1;
      foreach (stim_q[i]) begin
         b = stim_q[i];
         if (n == 0) tu = b.tu;
         kl = kl + fdiv(longint'(b.p) *
                        (longint'(b.lp) - longint'(b.lq)));
         if (SAT) begin
            if (kl > hi) begin kl = hi; st = 1; end
            else if (kl < lo) begin kl = lo; st = 1; end
         end
         sc = sc + longint'(b.sc);
         if (sc > umax) sc = umax;
         n++;
         pw = pw + int'(b.pwl);
         pz = pz | b.pz;
         if (b.last || n == kmax) begin
            r = mk(pz ? 0 : wrap(kl, wacc), sc, n, pw, tu, pz,
                   !b.last && n == kmax, st);
            exp_q.push_back(r);
            kl = 0; sc = 0; n = 0; pw = 0; pz = 0; st = 0;
         end
      end
   endfunction

   task automatic drive(input beat_t b);
      in_prob_p = b.p; in_log_p = b.lp; in_log_q = b.lq;
      in_log_score = b.sc; in_tuser = b.tu; in_last = b.last;
      in_use_pwl = b.pwl; in_poison = b.pz;
   endtask

   function automatic beat_t bt(
      input logic [15:0] p, input logic [15:0] lp,
      input logic [15:0] lq, input logic [15:0] sc,
      input logic [7:0] tu, input logic last,
      input logic pwl, input logic pz
   );
      beat_t b;
      b.p = p; b.lp = lp; b.lq = lq; b.sc = sc;
      b.tu = tu; b.last = last; b.pwl = pwl; b.pz = pz;
      return b;
   endfunction

   function automatic beat_t rand_beat(input bit big);
      beat_t b;
      b.p  = 16'($urandom);
      b.lp = 16'($urandom);
      b.lq = 16'($urandom);
      if (big && $urandom_range(1) == 1) begin
         b.p = 16'hFFFF; b.lp = 16'hFFFF; b.lq = 16'h0000;
      end
      b.sc = 16'($urandom);
      b.tu = 8'($urandom);
      b.last = 1'b0;
      b.pwl = 1'($urandom_range(1));
      b.pz = ($urandom_range(9) == 0);
      return b;
   endfunction

   task automatic build_random(input int nf, input bit skip4,
                               input bit big);
      int len;
      beat_t b;
      stim_q.delete();
      for (int f = 0; f < nf; f++) begin
         len = int'($urandom_range(6, 1));
         if (skip4 && len == 4) len = 5;
         for (int k = 0; k < len; k++) begin
            b = rand_beat(big);
            b.last = (k == len - 1);
            stim_q.push_back(b);
         end
      end
   endtask

   // Called at posedge+1; returns at posedge+1 with outputs drained.
   task automatic run(input int rdy_pct, input int vld_pct);
      int budget;
      bit acc;
      budget = 4000;
      got_q.delete();
      beats_q = stim_q;
      while ((beats_q.size() > 0 || m_valid) && budget > 0) begin
         out_ready = (int'($urandom_range(99)) < rdy_pct);
         in_valid = 1'b0;
         if (beats_q.size() > 0 &&
             int'($urandom_range(99)) < vld_pct) begin
            drive(beats_q[0]);
            in_valid = 1'b1;
         end
         #1;
         if (out_ready && !m_in_ready) bubbles++;
         if (m_valid && out_ready) got_q.push_back(m);
         acc = in_valid && m_in_ready;
         @(posedge clk); #1;
         if (acc) void'(beats_q.pop_front());
         budget--;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (budget == 0) begin
         failures++;
         $display("FAIL run_timeout got=expired exp=drained");
      end
   endtask

   task automatic check_run(input string name);
      chk({name, " nrec"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         cmp_rec($sformatf("%s[%0d]", name, i), got_q[i], exp_q[i]);
      exp_q.delete();
   endtask

   vec_t tbl[8];
   rec_t e;

   initial begin
      tbl[0] = '{16'h8000, 16'd10, 16'd8, 16'd5, 8'h5A, 1'b0, 1'b0, 1};
      tbl[1] = '{16'h8000, 16'd8, 16'd10, 16'd7, 8'h11, 1'b0, 1'b0, -1};
      tbl[2] = '{16'hFFFF, 16'hFFFF, 16'h0, 16'hFFFF, 8'h22, 1'b1,
                 1'b0, 65534};
      tbl[3] = '{16'hFFFF, 16'h0, 16'hFFFF, 16'd0, 8'h33, 1'b0,
                 1'b0, -65535};
      tbl[4] = '{16'h0000, 16'd100, 16'd0, 16'd9, 8'h44, 1'b0, 1'b0, 0};
      tbl[5] = '{16'h0001, 16'd3, 16'd4, 16'd1, 8'h55, 1'b1, 1'b0, -1};
      tbl[6] = '{16'h8000, 16'd10, 16'd8, 16'd2, 8'h66, 1'b0, 1'b1, 0};
      tbl[7] = '{16'h4000, 16'd20, 16'd0, 16'd3, 8'hFF, 1'b1, 1'b0, 5};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst out_valid", o0_valid, 0);
      chk("rst out_kl", o0_kl, 0);
      chk("rst out_score", o0_score, 0);
      chk("rst out_count", o0_count, 0);
      chk("rst out_tuser", o0_tu, 0);
      chk("rst out_poison", o0_pz, 0);
      chk("rst in_ready", o0_ready, 1);
      @(posedge clk); #1;

      sel = 3'b001;
      out_ready = 1'b1;
      drive(bt(16'h8000, 16'd10, 16'd8, 16'd5, 8'h5A, 1, 0, 0));
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("lat out_valid", o0_valid, 1);
      chk("lat out_kl", $signed(o0_kl), 1);
      chk("lat out_count", o0_count, 1);
      chk("lat out_tuser", o0_tu, 8'h5A);
      @(posedge clk); #1;
      chk("lat drop", o0_valid, 0);
      out_ready = 1'b0;

      for (int i = 0; i < 8; i++) begin
         stim_q.delete();
         stim_q.push_back(bt(tbl[i].p, tbl[i].lp, tbl[i].lq,
                             tbl[i].sc, tbl[i].tu, 1'b1,
                             tbl[i].pwl, tbl[i].pz));
         run(100, 100);
         chk($sformatf("tbl%0d nrec", i), got_q.size(), 1);
         if (got_q.size() > 0) begin
            e = mk(tbl[i].kl, tbl[i].sc, 1, int'(tbl[i].pwl),
                   tbl[i].tu, tbl[i].pz, 1'b0, 1'b0);
            cmp_rec($sformatf("tbl%0d", i), got_q[0], e);
         end
      end

      stim_q.delete();
      stim_q.push_back(bt(16'h8000, 16'd8, 16'd10, 16'd100, 8'h01,
                          0, 0, 0));
      stim_q.push_back(bt(16'hFFFF, 16'd4, 16'd4, 16'd200, 8'h02,
                          1, 0, 0));
      run(100, 100);
      chk("two nrec", got_q.size(), 1);
      if (got_q.size() > 0) begin
         e = mk(-1, 300, 2, 0, 8'h01, 0, 0, 0);
         cmp_rec("two", got_q[0], e);
      end

      out_ready = 1'b0;
      drive(bt(16'h8000, 16'd10, 16'd8, 16'd1, 8'hA1, 0, 0, 0));
      in_valid = 1'b1;
      @(posedge clk); #1;
      drive(bt(16'h1234, 16'd50, 16'd3, 16'd1, 8'hA2, 0, 0, 1));
      @(posedge clk); #1;
      drive(bt(16'h4000, 16'd7, 16'd9, 16'd1, 8'hA3, 1, 0, 0));
      @(posedge clk); #1;
      drive(bt(16'h8000, 16'd10, 16'd8, 16'd4, 8'h77, 1, 0, 0));
      for (int c = 0; c < 5; c++) begin
         chk("stall out_valid", o0_valid, 1);
         chk("stall out_kl", o0_kl, 0);
         chk("stall out_poison", o0_pz, 1);
         chk("stall out_count", o0_count, 3);
         chk("stall in_ready", o0_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("release out_valid", o0_valid, 1);
      chk("release out_kl", $signed(o0_kl), 1);
      chk("release out_count", o0_count, 1);
      chk("release out_tuser", o0_tu, 8'h77);
      chk("release out_poison", o0_pz, 0);
      @(posedge clk); #1;
      chk("release drop", o0_valid, 0);
      out_ready = 1'b0;

      stim_q.delete();
      for (int i = 0; i < 3; i++)
         stim_q.push_back(bt(16'h8000, 16'(10 + i), 16'd8, 16'(i),
                             8'(8'hB0 + i), 1, 0, 0));
      model(4096, 32);
      bubbles = 0;
      run(100, 100);
      chk("b2b bubbles", bubbles, 0);
      check_run("b2b");

      build_random(40, 1'b0, 1'b0);
      model(4096, 32);
      run(70, 80);
      check_run("rnd_main");

      sel = 3'b010;
      stim_q.delete();
      for (int i = 0; i < 6; i++)
         stim_q.push_back(bt(16'h8000, 16'd12, 16'd8, 16'd10,
                             8'(8'hC0 + i), i == 5, 1, 0));
      model(4, 32);
      run(100, 100);
      chk("k4 nrec", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("k4 rec0 count", got_q[0].count, 4);
         chk("k4 rec0 trunc", got_q[0].tr, 1);
         chk("k4 rec0 kl", got_q[0].kl, 8);
         chk("k4 rec1 count", got_q[1].count, 2);
         chk("k4 rec1 tuser", got_q[1].tu, 8'hC4);
         chk("k4 rec1 trunc", got_q[1].tr, 0);
      end
      check_run("k4");

      build_random(30, 1'b1, 1'b0);
      model(4, 32);
      run(70, 80);
      check_run("rnd_k4");

      sel = 3'b100;
      stim_q.delete();
      for (int i = 0; i < 5; i++)
         stim_q.push_back(bt(16'hFFFF, 16'h7FFF, 16'h0, 16'd0,
                             8'hD0, i == 4, 0, 0));
      model(4096, 18);
      run(100, 100);
      chk("a18 nrec", got_q.size(), 1);
      if (got_q.size() > 0) begin
         chk("a18 kl", got_q[0].kl, SAT ? 131071 : -98314);
         chk("a18 sat", got_q[0].st, SAT);
      end
      check_run("a18");

      build_random(30, 1'b0, 1'b1);
      model(4096, 18);
      run(70, 80);
      check_run("rnd_a18");

      sel = 3'b001;
      out_ready = 1'b1;
      drive(bt(16'hFFFF, 16'hFFFF, 16'h0, 16'd50, 8'hE1, 0, 1, 0));
      in_valid = 1'b1;
      @(posedge clk); #1;
      drive(bt(16'hFFFF, 16'hFFFF, 16'h0, 16'd50, 8'hE2, 0, 1, 1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid rst out_valid", o0_valid, 0);
      chk("mid rst out_count", o0_count, 0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      stim_q.delete();
      stim_q.push_back(bt(16'h8000, 16'd10, 16'd8, 16'd3, 8'hE3,
                          1, 0, 0));
      run(100, 100);
      chk("post rst nrec", got_q.size(), 1);
      if (got_q.size() > 0) begin
         e = mk(1, 3, 1, 0, 8'hE3, 0, 0, 0);
         cmp_rec("post rst", got_q[0], e);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
